// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared BCD digit type, digit limits and load clamp helper.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Any nibble above 9 is not a decimal digit; saturate it to 9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One BCD decade with clear, clamped load and up/down step.
//            Rolls over 9->0 going up and 0->9 going down; the parent decides
//            when a step is allowed (carry/borrow chain and saturation).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic       clear,
  input  bcd_digit_t din,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  // Next digit value: clear beats load, load beats stepping.
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = BCD_MIN;
    end else if (load) begin
      q_d = bcd_clamp(din);
    end else if (step) begin
      if (up) begin
        q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  // Digit register with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);
  assign at_min = (q_q == BCD_MIN);

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_updown_counter
// Purpose  : DIGITS-decade BCD up/down counter with clear, clamped load,
//            combinational terminal count and a registered wrap/saturate
//            event pulse. WRAP=1 rolls over at the ends, WRAP=0 holds there.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  event_o
);

  // w_low_max[i] / w_low_min[i]: every digit below i is at 9 / at 0.
  logic [DIGITS:0]   w_low_max;
  logic [DIGITS:0]   w_low_min;
  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_min;
  logic [DIGITS-1:0] w_step;
  logic              w_hold;
  logic              event_q;

  assign w_low_max[0] = 1'b1;
  assign w_low_min[0] = 1'b1;

  // Terminal count only when a real count step is requested at the boundary.
  assign tc = ~reset & en & ~load & ~clear &
              (up ? w_low_max[DIGITS] : w_low_min[DIGITS]);

  // In saturate mode the boundary step is suppressed for all digits.
  assign w_hold = (WRAP == 0) & tc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .reset  (reset),
      .step   (w_step[i]),
      .up     (up),
      .load   (load),
      .clear  (clear),
      .din    (load_val[4*i +: 4]),
      .q      (count[4*i +: 4]),
      .at_max (w_at_max[i]),
      .at_min (w_at_min[i])
    );

    assign w_step[i]      = en & ~w_hold & (up ? w_low_max[i] : w_low_min[i]);
    assign w_low_max[i+1] = w_low_max[i] & w_at_max[i];
    assign w_low_min[i+1] = w_low_min[i] & w_at_min[i];
  end

  // Event pulse: one cycle after a sampled terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= 1'b0;
    end else begin
      event_q <= tc;
    end
  end

  assign event_o = event_q;

endmodule : bcd_updown_counter
`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_updown_counter
// Purpose  : Directed self-checking bench; a wrapping and a saturating
//            two-digit instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       up;

  logic [7:0] count_w;
  logic       tc_w;
  logic       event_w;
  logic [7:0] count_s;
  logic       tc_s;
  logic       event_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(2), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(count_w), .tc(tc_w), .event_o(event_w)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(count_s), .tc(tc_s), .event_o(event_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00; en = 1'b0; up = 1'b1;
    tick; tick;

    // tc must be masked while reset is high, even at 00 counting down.
    en = 1'b0; up = 1'b0; #1;
    en = 1'b1; #1;
    check("tc_in_reset", 32'(tc_w), 0);
    tick;
    check("reset_count", 32'(count_w), 32'h00);
    check("reset_event", 32'(event_w), 0);

    // Up count 00..99 and wrap back to 00.
    reset = 1'b0; en = 1'b1; up = 1'b1; #1;
    for (int k = 0; k < 100; k++) begin
      check("up_tc", 32'(tc_w), (k == 99) ? 1 : 0);
      tick;
      check("up_count", 32'(count_w), 32'(to_bcd((k + 1) % 100)));
      check("up_event", 32'(event_w), (k == 99) ? 1 : 0);
    end
    en = 1'b0;

    // Down wrap from 00.
    load = 1'b1; load_val = 8'h00; tick;
    load = 1'b0;
    check("load_00", 32'(count_w), 32'h00);
    en = 1'b1; up = 1'b0; #1;
    check("down_tc", 32'(tc_w), 1);
    tick;
    check("down_wrap", 32'(count_w), 32'h99);
    check("down_wrap_event", 32'(event_w), 1);
    tick;
    check("down_98", 32'(count_w), 32'h98);
    check("down_98_event", 32'(event_w), 0);
    en = 1'b0;

    // Borrow across decades.
    load = 1'b1; load_val = 8'h30; tick;
    load = 1'b0; en = 1'b1; up = 1'b0; tick;
    check("borrow_29", 32'(count_w), 32'h29);
    en = 1'b0;

    // Direction changes between cycles, no lost or extra step.
    load = 1'b1; load_val = 8'h19; tick;
    load = 1'b0; en = 1'b1; up = 1'b1; tick;
    check("dir_up_20", 32'(count_w), 32'h20);
    up = 1'b0; tick;
    check("dir_down_19", 32'(count_w), 32'h19);
    up = 1'b1; tick;
    check("dir_up_20b", 32'(count_w), 32'h20);
    en = 1'b0;

    // Saturate up on the WRAP=0 instance; wrapping instance rolls over.
    load = 1'b1; load_val = 8'h98; tick;
    load = 1'b0; en = 1'b1; up = 1'b1; tick;
    check("sat_c1", 32'(count_s), 32'h99);
    check("sat_e1", 32'(event_s), 0);
    check("wrap_c1", 32'(count_w), 32'h99);
    tick;
    check("sat_c2", 32'(count_s), 32'h99);
    check("sat_e2", 32'(event_s), 1);
    check("wrap_c2", 32'(count_w), 32'h00);
    tick;
    check("sat_c3", 32'(count_s), 32'h99);
    check("sat_e3", 32'(event_s), 1);
    en = 1'b0; tick;
    check("sat_idle_c", 32'(count_s), 32'h99);
    check("sat_idle_e", 32'(event_s), 0);

    // Saturate down at 00.
    load = 1'b1; load_val = 8'h00; tick;
    load = 1'b0; en = 1'b1; up = 1'b0; #1;
    check("sat_dn_tc", 32'(tc_s), 1);
    tick;
    check("sat_dn_c", 32'(count_s), 32'h00);
    check("sat_dn_e", 32'(event_s), 1);
    en = 1'b0;

    // Load clamps non-BCD nibbles; load never raises the event.
    load = 1'b1; load_val = 8'hA5; tick;
    check("clamp_A5", 32'(count_w), 32'h95);
    load_val = 8'h3F; en = 1'b1; up = 1'b1; tick;
    check("clamp_3F", 32'(count_w), 32'h39);
    check("clamp_3F_s", 32'(count_s), 32'h39);
    load_val = 8'hFF; #1;
    check("load_tc", 32'(tc_w), 0);
    tick;
    check("load_FF", 32'(count_w), 32'h99);
    check("load_event", 32'(event_w), 0);
    load = 1'b0; en = 1'b0;

    // Priority: clear over load over en.
    load = 1'b1; load_val = 8'h42; tick;
    check("prio_42", 32'(count_w), 32'h42);
    clear = 1'b1; load = 1'b1; load_val = 8'h77; en = 1'b1; up = 1'b1; tick;
    check("prio_clear", 32'(count_w), 32'h00);
    check("prio_clear_event", 32'(event_w), 0);
    clear = 1'b0; tick;
    check("prio_load", 32'(count_w), 32'h77);
    load = 1'b0; en = 1'b0;

    // Reset mid-count overrides load and en.
    load = 1'b1; load_val = 8'h58; tick;
    check("mid_58", 32'(count_w), 32'h58);
    reset = 1'b1; load_val = 8'h77; en = 1'b1; #1;
    check("mid_tc", 32'(tc_w), 0);
    tick;
    check("mid_count", 32'(count_w), 32'h00);
    check("mid_event", 32'(event_w), 0);
    check("mid_tc_after", 32'(tc_w), 0);
    reset = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; tick;
    check("resume_01", 32'(count_w), 32'h01);
    en = 1'b0; tick;
    check("idle_hold", 32'(count_w), 32'h01);
    check("idle_event", 32'(event_w), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bcd_updown_counter
`default_nettype wire

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2: number of cascaded BCD decades, legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 means roll over at a boundary, 0 means saturate at it.
REQ-003 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port clear, input, 1: synchronous clear of the count to zero.
REQ-006 Port load, input, 1: synchronous parallel load from load_val.
REQ-007 Port load_val, input, 4*DIGITS: BCD load value; digit 0 is the least significant nibble in bits [3:0].
REQ-008 Port en, input, 1: count enable.
REQ-009 Port up, input, 1: direction; 1 counts up, 0 counts down.
REQ-010 Port count, output, 4*DIGITS: registered BCD count; digit i is in bits [4i+3:4i].
REQ-011 Port tc, output, 1: combinational terminal count.
REQ-012 Port event_o, output, 1: registered one-cycle pulse marking a wrap or a saturation hit.

Function
REQ-013 Priority of operations: reset, then clear, then load, then en; idle otherwise.
REQ-014 Idle (no operation active) SHALL hold count unchanged.
REQ-015 Up count: digit 0 increments every enabled cycle; digit 9 goes to 0 and generates a carry.
REQ-016 Digit i>0 SHALL increment only when all lower digits are 9 and up=1.
REQ-017 Down count: digit 0 decrements; digit 0 goes to 9 and generates a borrow.
REQ-018 Digit i>0 SHALL decrement only when all lower digits are 0 and up=0.
REQ-019 Count update latency SHALL be 1 clock from the sampled inputs.
REQ-020 tc SHALL be 1 when en=1, load=0, clear=0, and one of:
  - up=1 and all digits are 9;
  - up=0 and all digits are 0.
REQ-021 Boundary with WRAP=1: all-9s going up becomes all-0s; all-0s going down becomes all-9s.
REQ-022 Boundary with WRAP=0: count holds at all-9s (up) or at all-0s (down).
REQ-023 event_o SHALL be 1 in the cycle after a cycle where tc=1 was sampled, and 0 otherwise.
REQ-024 Load with a digit value greater than 9 SHALL store 9 for that digit; the other digits load unchanged.
REQ-025 Load and clear SHALL never produce event_o.
REQ-026 A change of direction between cycles SHALL take effect on the next enabled cycle, with no lost or extra step.
REQ-027 count SHALL never hold a non-BCD nibble.

Reset
REQ-028 On reset, count SHALL be 0 and event_o SHALL be 0.
REQ-029 tc SHALL be 0 while reset is high.
REQ-030 Reset asserted mid-count SHALL override clear, load and en in the same cycle.
REQ-031 Counting SHALL resume from 0 on the first enabled cycle after reset deasserts.

Structure
REQ-032 Shared package bcd_pkg SHALL hold:
  - typedef bcd_digit_t (4-bit);
  - constants BCD_MAX=9 and BCD_MIN=0;
  - function bcd_clamp.
REQ-033 Sub-module bcd_digit SHALL implement one decade:
  - inputs: step, up, load, clear, din;
  - outputs: q, at_max, at_min.
REQ-034 The top level SHALL instantiate DIGITS copies of bcd_digit in a generate loop.
REQ-035 The top level SHALL build the carry/borrow enable chain, tc, WRAP handling and the event_o register.

Verification
REQ-036 Up wrap (DIGITS=2, WRAP=1): reset, then en=1, up=1 for 100 cycles -> count steps 00..99, returns to 00; tc=1 only at 99; event_o=1 the cycle after.
REQ-037 Down wrap (WRAP=1): load 0x00, then en=1, up=0 -> next count 99, event_o=1 one cycle later.
REQ-038 Saturate (WRAP=0): load 0x98, en=1, up=1 for 3 cycles -> count 99, 99, 99; event_o=1 on each cycle after tc.
REQ-039 Load clamp: load_val=0xA5 -> count 95; load_val=0x3F -> count 39.
REQ-040 Priority: at count 42 with clear=1, load=1 (0x77) and en=1 -> count 00; the next cycle with load=1 and en=1 -> count 77.
REQ-041 Reset mid-count: at count 58, reset=1 together with load=1 -> count 00, event_o=0, tc=0.
